// File: rtl/htif_pkg.sv
// Shared types, constants and field helpers for the HTIF tohost/fromhost mailbox.
package htif_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    PUTC,
    RESP,
    EXIT
  } htif_state_e;

  localparam logic [7:0] HTIF_DEV_BCD  = 8'd1;
  localparam logic [7:0] HTIF_CMD_PUTC = 8'd1;

  // Device field of a tohost command word.
  function automatic logic [7:0] htif_dev(input logic [63:0] v);
    return v[63:56];
  endfunction

  // Command field of a tohost command word.
  function automatic logic [7:0] htif_cmd(input logic [63:0] v);
    return v[55:48];
  endfunction

  // Payload field of a tohost command word.
  function automatic logic [47:0] htif_payload(input logic [63:0] v);
    return v[47:0];
  endfunction

  // An exit request has the LSB set and an empty device/command header.
  function automatic logic htif_is_exit(input logic [63:0] v);
    return v[0] && (v[63:48] == 16'h0);
  endfunction

  // Byte-enable merge of new write data into an existing register value.
  function automatic logic [63:0] htif_merge(input logic [63:0] oldVal,
                                             input logic [63:0] newVal,
                                             input logic [7:0]  be);
    logic [63:0] res;
    res = oldVal;
    for (int i = 0; i < 8; i++) begin
      if (be[i]) begin
        res[i*8 +: 8] = newVal[i*8 +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/htif_tohost_responder.sv
// Host-side end of the HTIF mailbox: a memory-mapped slave holding TOHOST and
// FROMHOST, decoding exit and console-putchar commands written by the core.
module htif_tohost_responder
  import htif_pkg::*;
#(
  parameter int          XLEN          = 64,
  parameter logic [63:0] TOHOST_ADDR   = 64'h8000_1000,
  parameter logic [63:0] FROMHOST_ADDR = 64'h8000_1040
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [63:0]       addr_i,
  input  logic [XLEN-1:0]   wdata_i,
  input  logic [XLEN/8-1:0] be_i,
  output logic              gnt_o,
  output logic              rvalid_o,
  output logic [XLEN-1:0]   rdata_o,
  output logic              exit_valid_o,
  output logic [XLEN-2:0]   exit_code_o,
  output logic              char_valid_o,
  output logic [7:0]        char_o,
  input  logic              char_ready_i,
  output logic              unsupported_o
);

  if (XLEN != 64) begin : g_badXlen
    $error("htif_tohost_responder supports only XLEN=64");
  end

  htif_state_e r_state;
  htif_state_e w_stateNext;

  logic [63:0] r_tohost;
  logic [63:0] r_fromhost;
  logic [15:0] r_devCmd;
  logic [62:0] r_exitCode;
  logic        r_rvalid;
  logic [63:0] r_rdata;

  logic        w_hitTo;
  logic        w_hitFrom;
  logic        w_gnt;
  logic        w_toWr;
  logic        w_fromWr;
  logic        w_rd;
  logic [63:0] w_toMerged;
  logic [63:0] w_fromMerged;
  logic        w_trigger;
  logic        w_clearTo;
  logic        w_respPost;
  logic        w_captureExit;
  logic        w_charValid;
  logic        w_unsupported;
  logic        w_unused;

  // Byte-offset bits are irrelevant for 8-byte registers.
  assign w_unused = ^addr_i[2:0];

  assign w_hitTo   = (addr_i[63:3] == TOHOST_ADDR[63:3]);
  assign w_hitFrom = (addr_i[63:3] == FROMHOST_ADDR[63:3]);

  // Grant: FROMHOST and TOHOST reads always; TOHOST writes only while idle so a
  // pending command is never overwritten.
  always_comb begin
    w_gnt = 1'b0;
    if (req_i) begin
      if (w_hitFrom) begin
        w_gnt = 1'b1;
      end else if (w_hitTo) begin
        w_gnt = !we_i || (r_state == IDLE);
      end
    end
  end

  assign w_toWr       = w_gnt && we_i && w_hitTo && !w_hitFrom;
  assign w_fromWr     = w_gnt && we_i && w_hitFrom;
  assign w_rd         = w_gnt && !we_i;
  assign w_toMerged   = htif_merge(r_tohost, wdata_i, be_i);
  assign w_fromMerged = htif_merge(r_fromhost, wdata_i, be_i);
  assign w_trigger    = w_toWr && be_i[7] && (w_toMerged != 64'h0);

  // Next-state and command decode; the upper byte write completes a command.
  always_comb begin
    w_stateNext   = r_state;
    w_clearTo     = 1'b0;
    w_respPost    = 1'b0;
    w_captureExit = 1'b0;
    w_charValid   = 1'b0;
    w_unsupported = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_trigger) begin
          w_stateNext = DECODE;
        end
      end
      DECODE: begin
        if (htif_is_exit(r_tohost)) begin
          w_captureExit = 1'b1;
          w_clearTo     = 1'b1;
          w_stateNext   = EXIT;
        end else if ((htif_dev(r_tohost) == HTIF_DEV_BCD) &&
                     (htif_cmd(r_tohost) == HTIF_CMD_PUTC)) begin
          w_stateNext = PUTC;
        end else begin
          w_unsupported = 1'b1;
          w_clearTo     = 1'b1;
          w_stateNext   = IDLE;
        end
      end
      PUTC: begin
        w_charValid = 1'b1;
        if (char_ready_i) begin
          w_clearTo   = 1'b1;
          w_stateNext = RESP;
        end
      end
      RESP: begin
        if ((r_fromhost == 64'h0) && !w_fromWr) begin
          w_respPost  = 1'b1;
          w_stateNext = IDLE;
        end
      end
      EXIT: begin
        w_stateNext = EXIT;
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // TOHOST: core writes only land in IDLE, FSM clears only outside IDLE.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_tohost <= 64'h0;
    end else if (w_clearTo) begin
      r_tohost <= 64'h0;
    end else if (w_toWr) begin
      r_tohost <= w_toMerged;
    end
  end

  // FROMHOST: a core write in the same cycle wins over the response post.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_fromhost <= 64'h0;
    end else if (w_fromWr) begin
      r_fromhost <= w_fromMerged;
    end else if (w_respPost) begin
      r_fromhost <= {r_devCmd, 48'h0};
    end
  end

  // Header and exit code survive the TOHOST clear for the response and exit report.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_devCmd   <= 16'h0;
      r_exitCode <= 63'h0;
    end else if (r_state == DECODE) begin
      r_devCmd <= r_tohost[63:48];
      if (w_captureExit) begin
        r_exitCode <= r_tohost[63:1];
      end
    end
  end

  // Read pipeline: value sampled at grant, presented one cycle later, zero otherwise.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rvalid <= 1'b0;
      r_rdata  <= 64'h0;
    end else begin
      r_rvalid <= w_rd;
      if (w_rd) begin
        r_rdata <= w_hitFrom ? r_fromhost : r_tohost;
      end else begin
        r_rdata <= 64'h0;
      end
    end
  end

  assign gnt_o         = w_gnt;
  assign rvalid_o      = r_rvalid;
  assign rdata_o       = r_rdata;
  assign exit_valid_o  = (r_state == EXIT);
  assign exit_code_o   = (r_state == EXIT) ? r_exitCode : 63'h0;
  assign char_valid_o  = w_charValid;
  assign char_o        = w_charValid ? r_tohost[7:0] : 8'h0;
  assign unsupported_o = w_unsupported;

endmodule

// File: tb/tb_htif_tohost_responder.sv
// Scoreboard bench for the HTIF responder: bus reads and console characters are
// queued as expectations at issue time and checked by an independent monitor.
module tb_htif_tohost_responder;

   localparam logic [63:0] TO_ADDR   = 64'h8000_1000;
   localparam logic [63:0] FROM_ADDR = 64'h8000_1040;
   localparam logic [63:0] RESP_PUTC = 64'h0101_0000_0000_0000;

   logic        clk;
   logic        rst;
   logic        req;
   logic        we;
   logic [63:0] addr;
   logic [63:0] wdata;
   logic [7:0]  be;
   logic        gnt;
   logic        rvalid;
   logic [63:0] rdata;
   logic        exitValid;
   logic [62:0] exitCode;
   logic        charValid;
   logic [7:0]  charOut;
   logic        charReady;
   logic        unsupported;

   int checks = 0;
   int passes = 0;

   logic [63:0] readQ[$];
   logic [7:0]  charQ[$];

   htif_tohost_responder dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .req_i        (req),
      .we_i         (we),
      .addr_i       (addr),
      .wdata_i      (wdata),
      .be_i         (be),
      .gnt_o        (gnt),
      .rvalid_o     (rvalid),
      .rdata_o      (rdata),
      .exit_valid_o (exitValid),
      .exit_code_o  (exitCode),
      .char_valid_o (charValid),
      .char_o       (charOut),
      .char_ready_i (charReady),
      .unsupported_o(unsupported)
   );

   // Free-running clock, 10 time units per cycle.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports any miss.
   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) begin
         passes++;
      end else begin
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One bus cycle; granted reads queue their expected data for the monitor.
   task automatic applyStimulus(input logic isWrite, input logic [63:0] a, input logic [63:0] d,
                                input logic [7:0] b, input logic expGnt, input logic [63:0] expRead,
                                input string name);
      req   = 1'b1;
      we    = isWrite;
      addr  = a;
      wdata = d;
      be    = b;
      @(negedge clk);
      checkOutput(name, {63'h0, gnt}, {63'h0, expGnt});
      if (!isWrite && expGnt) begin
         readQ.push_back(expRead);
      end
      @(posedge clk);
      #1;
      req   = 1'b0;
      we    = 1'b0;
      wdata = 64'h0;
      be    = 8'h0;
   endtask

   // Reset pulse spanning two edges, with the asynchronous effect checked mid-cycle.
   task automatic doReset();
      tick();
      rst = 1'b1;
      #1;
      checkOutput("rst_exit_valid", {63'h0, exitValid}, 64'h0);
      checkOutput("rst_char_valid", {63'h0, charValid}, 64'h0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // Monitor: compares read data and accepted characters against the queues.
   always @(negedge clk) begin
      if (!rst) begin
         if (rvalid) begin
            if (readQ.size() == 0) begin
               checkOutput("unexpected_rvalid", {63'h0, rvalid}, 64'h0);
            end else begin
               checkOutput("read_data", rdata, readQ.pop_front());
            end
         end
         if (charValid && charReady) begin
            if (charQ.size() == 0) begin
               checkOutput("unexpected_char", {63'h0, charValid}, 64'h0);
            end else begin
               checkOutput("char_data", {56'h0, charOut}, {56'h0, charQ.pop_front()});
            end
         end
      end
   end

   // Directed scenarios.
   initial begin
      rst       = 1'b0;
      req       = 1'b0;
      we        = 1'b0;
      addr      = 64'h0;
      wdata     = 64'h0;
      be        = 8'h0;
      charReady = 1'b0;
      #1;
      rst = 1'b1;
      #2;
      checkOutput("reset_exit_valid", {63'h0, exitValid}, 64'h0);
      checkOutput("reset_exit_code", {1'b0, exitCode}, 64'h0);
      checkOutput("reset_char_valid", {63'h0, charValid}, 64'h0);
      checkOutput("reset_char", {56'h0, charOut}, 64'h0);
      checkOutput("reset_rvalid", {63'h0, rvalid}, 64'h0);
      checkOutput("reset_rdata", rdata, 64'h0);
      checkOutput("reset_unsupported", {63'h0, unsupported}, 64'h0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Putchar with a stalled console sink.
      applyStimulus(1'b0, TO_ADDR, 64'h0, 8'hFF, 1'b1, 64'h0, "rd_to_init");
      applyStimulus(1'b0, FROM_ADDR, 64'h0, 8'hFF, 1'b1, 64'h0, "rd_from_init");
      applyStimulus(1'b0, 64'h8000_2000, 64'h0, 8'hFF, 1'b0, 64'h0, "rd_unmapped");
      charQ.push_back(8'h41);
      applyStimulus(1'b1, TO_ADDR, 64'h0101_0000_0000_0041, 8'hFF, 1'b1, 64'h0, "wr_putc_a");
      checkOutput("putc_lat_decode", {63'h0, charValid}, 64'h0);
      tick();
      checkOutput("putc_valid", {63'h0, charValid}, 64'h1);
      checkOutput("putc_char", {56'h0, charOut}, 64'h41);
      for (int i = 0; i < 4; i++) begin
         tick();
         checkOutput("putc_hold", {63'h0, charValid}, 64'h1);
      end
      applyStimulus(1'b1, TO_ADDR, 64'h0, 8'h0F, 1'b0, 64'h0, "wr_to_busy_putc");
      checkOutput("putc_hold_char", {56'h0, charOut}, 64'h41);
      charReady = 1'b1;
      tick();
      charReady = 1'b0;
      checkOutput("putc_done", {63'h0, charValid}, 64'h0);
      tick();
      applyStimulus(1'b0, FROM_ADDR, 64'h0, 8'hFF, 1'b1, RESP_PUTC, "rd_from_resp");
      applyStimulus(1'b0, TO_ADDR, 64'h0, 8'hFF, 1'b1, 64'h0, "rd_to_cleared");
      applyStimulus(1'b1, FROM_ADDR, 64'h0, 8'hFF, 1'b1, 64'h0, "wr_from_ack");

      // Response blocked by a busy FROMHOST; core write wins the retry cycle.
      applyStimulus(1'b1, FROM_ADDR, 64'h5, 8'hFF, 1'b1, 64'h0, "wr_from_preload");
      charReady = 1'b1;
      charQ.push_back(8'h42);
      applyStimulus(1'b1, TO_ADDR, 64'h0101_0000_0000_0042, 8'hFF, 1'b1, 64'h0, "wr_putc_b");
      tick();
      tick();
      charReady = 1'b0;
      tick();
      tick();
      applyStimulus(1'b0, FROM_ADDR, 64'h0, 8'hFF, 1'b1, 64'h5, "rd_from_busy");
      applyStimulus(1'b1, TO_ADDR, 64'h0, 8'h0F, 1'b0, 64'h0, "wr_to_in_resp");
      applyStimulus(1'b1, FROM_ADDR, 64'h0, 8'hFF, 1'b1, 64'h0, "wr_from_free");
      applyStimulus(1'b1, FROM_ADDR, 64'h7, 8'hFF, 1'b1, 64'h0, "wr_from_race");
      applyStimulus(1'b0, FROM_ADDR, 64'h0, 8'hFF, 1'b1, 64'h7, "rd_from_core_wins");
      applyStimulus(1'b1, TO_ADDR, 64'h0, 8'h0F, 1'b0, 64'h0, "wr_to_still_resp");
      applyStimulus(1'b1, FROM_ADDR, 64'h0, 8'hFF, 1'b1, 64'h0, "wr_from_free2");
      tick();
      applyStimulus(1'b0, FROM_ADDR, 64'h0, 8'hFF, 1'b1, RESP_PUTC, "rd_from_posted");
      applyStimulus(1'b1, TO_ADDR, 64'h0, 8'h0F, 1'b1, 64'h0, "wr_to_idle_again");
      applyStimulus(1'b1, FROM_ADDR, 64'h0, 8'hFF, 1'b1, 64'h0, "wr_from_ack2");

      // Unknown device/command is dropped with a single pulse.
      applyStimulus(1'b1, FROM_ADDR, 64'h9, 8'hFF, 1'b1, 64'h0, "wr_from_nine");
      applyStimulus(1'b1, TO_ADDR, 64'h0203_0000_0000_0000, 8'hFF, 1'b1, 64'h0, "wr_unsup");
      checkOutput("unsup_pulse", {63'h0, unsupported}, 64'h1);
      tick();
      checkOutput("unsup_single", {63'h0, unsupported}, 64'h0);
      applyStimulus(1'b0, TO_ADDR, 64'h0, 8'hFF, 1'b1, 64'h0, "rd_to_unsup");
      applyStimulus(1'b0, FROM_ADDR, 64'h0, 8'hFF, 1'b1, 64'h9, "rd_from_unchanged");
      applyStimulus(1'b1, TO_ADDR, 64'h0, 8'h0F, 1'b1, 64'h0, "wr_to_after_unsup");
      applyStimulus(1'b1, FROM_ADDR, 64'h0, 8'hFF, 1'b1, 64'h0, "wr_from_clear");

      // Split store: low half merges silently, high half triggers the exit.
      applyStimulus(1'b1, TO_ADDR, 64'h3, 8'h0F, 1'b1, 64'h0, "wr_split_lo");
      checkOutput("split_no_trig", {63'h0, exitValid}, 64'h0);
      tick();
      checkOutput("split_no_trig2", {63'h0, exitValid}, 64'h0);
      applyStimulus(1'b0, TO_ADDR, 64'h0, 8'hFF, 1'b1, 64'h3, "rd_to_split");
      applyStimulus(1'b1, TO_ADDR, 64'h0, 8'hF0, 1'b1, 64'h0, "wr_split_hi");
      checkOutput("split_exit_lat1", {63'h0, exitValid}, 64'h0);
      tick();
      checkOutput("split_exit_valid", {63'h0, exitValid}, 64'h1);
      checkOutput("split_exit_code", {1'b0, exitCode}, 64'h1);
      applyStimulus(1'b0, TO_ADDR, 64'h0, 8'hFF, 1'b1, 64'h0, "rd_to_exit");
      applyStimulus(1'b1, TO_ADDR, 64'h1, 8'hFF, 1'b0, 64'h0, "wr_to_after_exit");
      checkOutput("exit_sticky", {63'h0, exitValid}, 64'h1);
      doReset();
      checkOutput("exit_cleared", {63'h0, exitValid}, 64'h0);

      // Plain exit with code zero.
      applyStimulus(1'b1, TO_ADDR, 64'h1, 8'hFF, 1'b1, 64'h0, "wr_exit0");
      checkOutput("exit0_lat1", {63'h0, exitValid}, 64'h0);
      tick();
      checkOutput("exit0_valid", {63'h0, exitValid}, 64'h1);
      checkOutput("exit0_code", {1'b0, exitCode}, 64'h0);
      applyStimulus(1'b0, TO_ADDR, 64'h0, 8'hFF, 1'b1, 64'h0, "rd_to_exit0");
      doReset();

      // Reset in the middle of a putchar drops everything at once.
      applyStimulus(1'b1, FROM_ADDR, 64'h55, 8'hFF, 1'b1, 64'h0, "wr_from_55");
      applyStimulus(1'b1, TO_ADDR, 64'h0101_0000_0000_0043, 8'hFF, 1'b1, 64'h0, "wr_putc_c");
      tick();
      checkOutput("putc_c_valid", {63'h0, charValid}, 64'h1);
      rst = 1'b1;
      #1;
      checkOutput("rst_async_charvalid", {63'h0, charValid}, 64'h0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      applyStimulus(1'b0, TO_ADDR, 64'h0, 8'hFF, 1'b1, 64'h0, "rd_to_after_rst");
      applyStimulus(1'b0, FROM_ADDR, 64'h0, 8'hFF, 1'b1, 64'h0, "rd_from_after_rst");
      applyStimulus(1'b1, TO_ADDR, 64'h1, 8'hFF, 1'b1, 64'h0, "wr_after_rst");
      tick();
      checkOutput("exit_after_rst", {63'h0, exitValid}, 64'h1);

      tick();
      tick();
      checkOutput("readq_drained", 64'(readQ.size()), 64'h0);
      checkOutput("charq_drained", 64'(charQ.size()), 64'h0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
